// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin burst arbiter for two masters in front of the PSRAM controller.
// Optional read watchdog: define PSRAM_ARB_RD_TIMEOUT_EN.
module psram_arbiter #(
  parameter int TCMD = 19,
`ifdef PSRAM_ARB_RD_TIMEOUT_EN
  parameter int TIMEOUT = 255,
`endif
  parameter int NUM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_cmd,
  input  logic        m1_cmd,
  input  logic [20:0] m0_addr,
  input  logic [20:0] m1_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [31:0] m1_wr_data,
  output logic        m0_wr_pop,
  output logic        m1_wr_pop,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_rd_valid,
  output logic        m1_rd_valid,
  output logic [31:0] rd_data_out,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] addr,
  output logic [31:0] wr_data,
  output logic [3:0]  data_mask,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  output logic        owner,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_WR, S_RD, S_HOLD
  } state_t;

  localparam int BW = (NUM > 2) ? $clog2(NUM) : 1;
  localparam logic [BW-1:0] W_LAST = BW'(NUM-2);
  localparam logic [BW-1:0] R_LAST = BW'(NUM-1);
  localparam logic [5:0] GAP_MAX = 6'(TCMD-1);

  state_t r_state, w_next;
  logic [5:0] r_gap;
  logic [BW-1:0] r_beat;
  logic r_first;
  logic r_last;

  logic w_grant, w_win, w_wcmd;
  logic w_rd_acc, w_rd_done, w_to;
  logic w_sel;
  logic [20:0] w_addr;
  logic [31:0] w_head;

`ifdef PSRAM_ARB_RD_TIMEOUT_EN
  logic [7:0] r_wd;
`endif

  always_comb begin
    w_win = (m0_req && m1_req) ? ~r_last : m1_req;
    w_wcmd = w_win ? m1_cmd : m0_cmd;
    w_addr = w_win ? m1_addr : m0_addr;
    w_grant = (r_state == S_ARB) && (m0_req || m1_req)
            && (r_first || (r_gap >= GAP_MAX));
    w_rd_acc = (r_state == S_RD) && rd_data_valid;
    w_rd_done = w_rd_acc && (r_beat == R_LAST);
    w_sel = (r_state == S_WR) ? owner : w_win;
    w_head = w_sel ? m1_wr_data : m0_wr_data;
`ifdef PSRAM_ARB_RD_TIMEOUT_EN
    w_to = (r_state == S_RD) && !w_rd_done
         && (r_wd == 8'(TIMEOUT-1));
`else
    w_to = 1'b0;
`endif
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (init_done) w_next = S_ARB;
      S_ARB:  if (w_grant) w_next = w_wcmd ? S_WR : S_RD;
      S_WR:   if (r_beat == W_LAST) w_next = S_HOLD;
      S_RD:   if (w_rd_done || w_to) w_next = S_HOLD;
      S_HOLD: w_next = S_ARB;
      default: w_next = S_IDLE;
    endcase
  end

  // Pops are combinational so the FWFT head is consumed on the latching edge
  assign m0_wr_pop = (w_grant && w_wcmd && !w_win)
                   || ((r_state == S_WR) && !owner);
  assign m1_wr_pop = (w_grant && w_wcmd && w_win)
                   || ((r_state == S_WR) && owner);
  assign busy = (r_state != S_IDLE) && (r_state != S_ARB);
  assign data_mask = 4'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap       <= '0;
      r_beat      <= '0;
      r_first     <= 1'b1;
      r_last      <= 1'b1;
      cmd_en      <= 1'b0;
      cmd         <= 1'b0;
      addr        <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      owner       <= 1'b0;
      wr_data     <= '0;
      rd_data_out <= '0;
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      cmd_en <= w_grant;
      cmd    <= w_grant && w_wcmd;
      addr   <= w_grant ? w_addr : '0;
      m0_ack <= w_grant && !w_win;
      m1_ack <= w_grant && w_win;
      if (w_grant) begin
        owner   <= w_win;
        r_last  <= w_win;
        r_first <= 1'b0;
        r_gap   <= '0;
        r_beat  <= '0;
      end else begin
        if (r_gap < GAP_MAX) r_gap <= r_gap + 6'd1;
        if ((r_state == S_WR) || w_rd_acc) r_beat <= r_beat + 1'b1;
      end
      if ((w_grant && w_wcmd) || (r_state == S_WR)) begin
        wr_data <= w_head;
      end else begin
        wr_data <= '0;
      end
      if (w_rd_acc) rd_data_out <= rd_data;
      m0_rd_valid <= w_rd_acc && !owner;
      m1_rd_valid <= w_rd_acc && owner;
      // Beats outside RD_WAIT are either stray or surplus; both are faults
      if ((rd_data_valid && (r_state != S_RD)) || w_to) error <= 1'b1;
    end
  end

`ifdef PSRAM_ARB_RD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else begin
      r_wd <= (r_state == S_RD) ? r_wd + 8'd1 : 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized self-checking bench for psram_arbiter.
// Controller responder and master FIFOs are modelled behaviourally.
module tb_psram_arbiter;
  localparam int NUM = 8;
  localparam int TCMD = 19;

  logic clk = 1'b0;
  logic rst_n, init_done;
  logic m0_req, m1_req, m0_cmd, m1_cmd;
  logic [20:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data;
  logic m0_wr_pop, m1_wr_pop, m0_ack, m1_ack;
  logic m0_rd_valid, m1_rd_valid;
  logic [31:0] rd_data_out, wr_data, rd_data;
  logic cmd, cmd_en, owner, busy, error, rd_data_valid;
  logic [20:0] addr;
  logic [3:0] data_mask;

  psram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_cmd(m0_cmd), .m1_cmd(m1_cmd),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_wr_pop(m0_wr_pop), .m1_wr_pop(m1_wr_pop),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid),
    .rd_data_out(rd_data_out), .cmd(cmd), .cmd_en(cmd_en),
    .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .owner(owner), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned p0 = 0;
  int unsigned p1 = 0;
  logic [31:0] base0, base1;
  always @(posedge clk) begin
    if (m0_wr_pop) p0 <= p0 + 1;
    if (m1_wr_pop) p1 <= p1 + 1;
  end
  assign m0_wr_data = base0 + p0;
  assign m1_wr_data = base1 + p1;

  logic [31:0] got0[$];
  logic [31:0] got1[$];
  int n_cmd = 0;
  int n_ack = 0;
  always @(negedge clk) begin
    if (m0_rd_valid) got0.push_back(rd_data_out);
    if (m1_rd_valid) got1.push_back(rd_data_out);
    if (cmd_en) n_cmd <= n_cmd + 1;
    if (m0_ack || m1_ack) n_ack <= n_ack + 1;
  end

  logic [31:0] pat [64][8];
  int rsp_beats = NUM;
  int stray_n = 0;
  int stray_done = 0;
  int nb_rd = 0;

  initial begin
    rd_data_valid = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (stray_n != stray_done) begin
        stray_done++;
        rd_data_valid = 1'b1;
        rd_data = 32'h5A5A_0001;
        @(negedge clk);
        rd_data_valid = 1'b0;
      end else if (rst_n && cmd_en && !cmd) begin
        for (int i = 0; i < rsp_beats; i++) begin
          rd_data_valid = 1'b1;
          rd_data = pat[nb_rd][i];
          @(negedge clk);
          rd_data_valid = 1'b0;
          if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        nb_rd = (nb_rd + 1) % 64;
      end
    end
  end

  bit last_m;
  int rb = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] out_vec();
    return {cmd_en, cmd, addr, wr_data, m0_ack, m1_ack,
            m0_rd_valid, m1_rd_valid, rd_data_out, owner,
            busy, error, m0_wr_pop, m1_wr_pop, data_mask};
  endfunction

  function automatic logic [20:0] rnd_addr();
    logic [20:0] a;
    a = 21'($urandom);
    if (a == 0) a = 21'h1;
    return a;
  endfunction

  task automatic wait_cmd(input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (cmd_en) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic push_exp(input bit m);
    for (int i = 0; i < NUM; i++) begin
      if (m) exp1.push_back(pat[rb][i]);
      else exp0.push_back(pat[rb][i]);
    end
    rb = (rb + 1) % 64;
  endtask

  task automatic chk_rd(input string tag);
    int bad;
    bad = 0;
    if (got0.size() != exp0.size()) bad++;
    if (got1.size() != exp1.size()) bad++;
    if (bad == 0) begin
      foreach (exp0[i]) if (got0[i] !== exp0[i]) bad++;
      foreach (exp1[i]) if (got1[i] !== exp1[i]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic after_grant(input bit m, input bit c,
                             input logic [20:0] a, input int unsigned pb);
    int bad;
    logic [31:0] b;
    chk("ack", {m1_ack, m0_ack}, m ? 2'b10 : 2'b01);
    chk("cmd", cmd, c);
    chk("addr", addr, a);
    last_m = m;
    if (m) m1_req = 1'b0;
    else m0_req = 1'b0;
    if (c) begin
      bad = 0;
      b = m ? base1 : base0;
      for (int i = 0; i < NUM; i++) begin
        if (wr_data !== b + pb + 32'(i)) bad++;
        @(negedge clk);
      end
      chk("wr_beats", bad, 0);
      chk("wr_tail", wr_data, 0);
      chk("wr_pops", (m ? p1 : p0) - pb, NUM);
    end else begin
      push_exp(m);
    end
  endtask

  task automatic do_burst(input bit m, input bit c, input logic [20:0] a);
    int n;
    int unsigned pb;
    pb = m ? p1 : p0;
    if (m) begin
      m1_cmd = c; m1_addr = a; m1_req = 1'b1;
    end else begin
      m0_cmd = c; m0_addr = a; m0_req = 1'b1;
    end
    wait_cmd(60, n);
    chk("grant_wait", n != 0, 1);
    after_grant(m, c, a, pb);
    if (!c) begin
      repeat (25) @(negedge clk);
      chk_rd("rd_data");
      chk("rd_nopop", (m ? p1 : p0) - pb, 0);
    end
  endtask

  initial begin
    int n, t, prev, g;
    bit p;
    logic [20:0] a0, a1;
    foreach (pat[i, j]) pat[i][j] = $urandom;
    rst_n = 1'b0; init_done = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_cmd = 1'b0; m1_cmd = 1'b0;
    m0_addr = '0; m1_addr = '0;
    base0 = 32'h0; base1 = 32'hC000_0000;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", out_vec(), 0);
    last_m = 1'b1;

    m0_cmd = 1'b1; m0_addr = 21'h10; m0_req = 1'b1;
    repeat (100) @(negedge clk);
    chk("no_init_cmd", n_cmd, 0);
    chk("no_init_ack", n_ack, 0);
    chk("no_init_pop", p0, 0);
    init_done = 1'b1;
    wait_cmd(3, n);
    chk("init_lat", (n != 0) && (n <= 3), 1);
    after_grant(1'b0, 1'b1, 21'h10, 0);

    a0 = rnd_addr(); a1 = rnd_addr();
    m0_cmd = 1'b0; m1_cmd = 1'b0;
    m0_addr = a0; m1_addr = a1;
    m0_req = 1'b1; m1_req = 1'b1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_cmd(60, n);
      chk("rr_wait", n != 0, 1);
      t = cyc;
      p = ~last_m;
      if (k > 0) chk("rr_spacing", t - prev, TCMD);
      prev = t;
      chk("rr_ack", {m1_ack, m0_ack}, p ? 2'b10 : 2'b01);
      chk("rr_addr", addr, p ? a1 : a0);
      chk("rr_cmd", cmd, 0);
      push_exp(p);
      last_m = p;
      if (p) begin a1 = rnd_addr(); m1_addr = a1; end
      else begin a0 = rnd_addr(); m0_addr = a0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (30) @(negedge clk);
    chk_rd("rr_rd");
    chk("rr_err", error, 0);

    for (int i = 0; i < NUM; i++) pat[rb][i] = 32'hA0 + 32'(i);
    do_burst(1'b1, 1'b0, rnd_addr());
    chk("m1_rd_err", error, 0);

    for (int j = 0; j < 8; j++) begin
      p = 1'($urandom_range(1, 0));
      if ($urandom_range(1, 0) == 1) begin
        base0 = $urandom | 32'h8000_0000;
        base1 = $urandom | 32'h8000_0000;
        do_burst(p, 1'b1, rnd_addr());
      end else begin
        do_burst(p, 1'b0, rnd_addr());
      end
    end
    chk("rand_err", error, 0);

    base0 = $urandom | 32'h8000_0000;
    m0_cmd = 1'b1; m0_addr = rnd_addr(); m0_req = 1'b1;
    wait_cmd(60, n);
    chk("mid_wait", n != 0, 1);
    m0_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", out_vec(), 0);
    t = n_cmd;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_reack", n_cmd - t, 0);

    g = got0.size() + got1.size();
    stray_n++;
    repeat (4) @(negedge clk);
    chk("stray_err", error, 1);
    chk("stray_rdv", got0.size() + got1.size() - g, 0);
    repeat (20) @(negedge clk);
    chk("err_sticky", error, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_clr", error, 0);
    rst_n = 1'b1;
    last_m = 1'b1;

`ifdef PSRAM_ARB_RD_TIMEOUT_EN
    rsp_beats = 3;
    m0_cmd = 1'b0; m1_cmd = 1'b0;
    a0 = rnd_addr(); a1 = rnd_addr();
    m0_addr = a0; m1_addr = a1;
    m0_req = 1'b1; m1_req = 1'b1;
    wait_cmd(10, n);
    chk("to_grant0", {n != 0, m1_ack, m0_ack}, 3'b101);
    t = cyc;
    m0_req = 1'b0;
    rb = (rb + 1) % 64;
    for (int i = 0; i < 300; i++) begin
      if (error) break;
      @(negedge clk);
    end
    chk("to_delay", cyc - t, 255);
    wait_cmd(60, n);
    chk("to_next", {n != 0, m1_ack, m0_ack, addr}, {3'b110, a1});
    m1_req = 1'b0;
    rb = (rb + 1) % 64;
    rsp_beats = NUM;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL time_limit got=%0d exp=finish", cyc);
    $fatal(1, "time limit");
  end
endmodule
